alu_share_ctrl: RTL
===================

// Module: alu_share_ctrl
// PURPOSE
//   Shares the single 16-bit ALU between two requesters: req 0 is the pipeline, req 1 is the debug/DMA port.
//   Per-requester valid/ready handshakes, round-robin arbitration, registered ALU issue, and result capture.
//   Owns the architectural {N,V,Z} flag register and feeds it back to the ALU as flag_reg.
//   Sits between the decode/debug masters and the ALU instance.
// PARAMETERS
//   DATA_W        16     operand/result width; matches the ALU
//   FLAG_WR_MASK  2'b01  bit i = 1: requester i's ops update the flag register
// PORTS
//   clk           in   1         system clock
//   rst           in   1         synchronous, active-high reset
//   req_valid     in   2         request valid, one bit per requester
//   req_ready     out  2         grant; handshake = req_valid[i] & req_ready[i]
//   req_op        in   8         {op1, op0}, 4-bit ALU opcode per requester
//   req_src0      in   2*DATA_W  {src0_1, src0_0}
//   req_src1      in   2*DATA_W  {src1_1, src1_0}
//   req_imm       in   2*DATA_W  {imm_1, imm_0}
//   rsp_valid     out  2         result valid for requester i; at most one bit set
//   rsp_ready     in   2         requester accepts the result
//   rsp_result    out  DATA_W    result; shared bus, qualified by rsp_valid
//   rsp_flags     out  3         {N,V,Z} returned by the ALU for this op
//   alu_op        out  4         registered opcode driven to the ALU
//   alu_src0      out  DATA_W    registered operand to the ALU
//   alu_src1      out  DATA_W    registered operand to the ALU
//   alu_imm       out  DATA_W    registered operand to the ALU
//   alu_flag_reg  out  3         current flag register, {N,V,Z}
//   alu_result    in   DATA_W    combinational ALU result
//   alu_flags     in   3         combinational ALU flags
// BEHAVIOUR
//   FSM states:
//   - IDLE:  no op in flight; req_ready may assert.
//   - ISSUE: one cycle; ALU inputs are stable.
//   - RESP:  rsp_valid held until rsp_ready.
//   Arbitration:
//   - req_ready is combinational. It asserts only in IDLE, or in RESP on the cycle the response handshakes.
//   - At most one req_ready bit is set per cycle.
//   - Round robin on last_gnt: both valid -> grant != last_gnt; one valid -> grant it.
//   - last_gnt updates on every handshake.
//   Handshake at cycle T:
//   - The granted op and operands are registered onto the alu_* buses; the FSM enters ISSUE at T+1.
//   - At the end of T+1: alu_result/alu_flags are captured into rsp_result/rsp_flags, the owner is
//     recorded, and the FSM enters RESP.
//   - Result latency: rsp_valid[owner] = 1 at T+2.
//   - If FLAG_WR_MASK[owner], the flag register <= alu_flags, also at the end of T+1.
//   - For non-flag ops the ALU passes flag_reg through, so the flag register is unchanged.
//   RESP:
//   - rsp_valid, rsp_result and rsp_flags are held stable until rsp_ready[owner].
//   - rsp_ready on the non-owner bit is ignored.
//   - On the handshake cycle, a new request may be granted in the same cycle. The FSM goes to ISSUE
//     next, giving back-to-back throughput of one op per 2 cycles.
//   - With no new request the FSM goes to IDLE.
//   Request-side rules:
//   - Op 4'hC-4'hF is issued normally; the ALU returns 0 and the flags are unchanged. No error signalling.
//   - Requesters hold req_* stable while valid and unready; the block does not check this.
//   - A requester may drop req_valid before grant; no penalty.
//   Reset (rst = 1, sampled at posedge):
//   - State IDLE; last_gnt = 1, so requester 0 wins first.
//   - Flag register 3'b000; rsp_valid 0; rsp_result 0; rsp_flags 0.
//   - alu_* outputs 0, i.e. ADD 0+0.
//   - Reset mid-operation: the in-flight op is discarded, no response is produced, and the flags
//     keep their reset value.
// STRUCTURE
//   Shared package alu_pkg:
//   - ALU opcode localparams ADD..LLB.
//   - Flag indices Z=0, V=1, N=2.
//   - DATA_W default.
//   - FSM state encoding: IDLE=2'd0, ISSUE=2'd1, RESP=2'd2.
//   One sub-module, rr_arb2: 2-way round-robin arbiter.
//   - Inputs: req[1:0], last_gnt, en. Output: one-hot gnt[1:0].
//   - Purely combinational; the last_gnt register lives in this block.
//   The ALU is not instantiated here; the top level wires alu_* to it.
// TESTING
//   1. Reset, then req0 ADD src0=16'h0003 src1=16'h0004 -> rsp_valid[0] 2 cycles after grant,
//      rsp_result=16'h0007, flags=3'b000.
//   2. Both valid in the same cycle, first time after reset -> req0 granted. Then req1 is granted on
//      req0's rsp handshake cycle; second rsp_valid[1] at +2.
//   3. req0 SUB 16'h0005-16'h0005 -> Z set, alu_flag_reg=3'b001. Then req1 SUB 16'h8000-16'h0001
//      -> rsp_flags=3'b010 but flag register stays 3'b001 (mask bit 1 = 0).
//   4. Hold rsp_ready[0]=0 for 5 cycles with req1 valid -> rsp_* stable; req_ready stays 0 throughout.
//   5. Assert rst during ISSUE -> next cycle IDLE, rsp_valid=0, flags=0; no response ever appears.
//   6. req0 op 4'hE -> rsp_result=16'h0000, flag register unchanged; FSM returns to IDLE normally.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU sharing controller: ALU
//               opcodes, flag bit positions, default datapath width and the
//               controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Default operand/result width of the ALU.
  localparam int DATA_W = 16;

  // ALU opcodes. 4'hC-4'hF are unassigned; the ALU returns 0 for them and
  // leaves the flags untouched.
  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_PADDSB = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_AND    = 4'h3;
  localparam logic [3:0] OP_NOR    = 4'h4;
  localparam logic [3:0] OP_SLL    = 4'h5;
  localparam logic [3:0] OP_SRL    = 4'h6;
  localparam logic [3:0] OP_SRA    = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;

  // Bit positions inside the {N,V,Z} flag vector.
  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // One-hot vector selecting requester idx out of two.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. Purely combinational; the
//               caller keeps the last-grant history and decides when a grant
//               may be given (en).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       en,
  output logic [1:0] gnt
);

  // Single requester wins outright; on contention the one not granted last
  // time wins. Nothing is granted while disabled.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_ctrl
// Description : Shares one ALU between the pipeline (requester 0) and the
//               debug/DMA port (requester 1). Round-robin grant, registered
//               ALU issue, result capture and ownership of the {N,V,Z} flag
//               register fed back to the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_ctrl #(
  parameter int         DATA_W       = alu_pkg::DATA_W,
  parameter logic [1:0] FLAG_WR_MASK = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  // request side
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [7:0]            req_op,
  input  logic [2*DATA_W-1:0]   req_src0,
  input  logic [2*DATA_W-1:0]   req_src1,
  input  logic [2*DATA_W-1:0]   req_imm,
  // response side
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_W-1:0]     rsp_result,
  output logic [2:0]            rsp_flags,
  // ALU side
  output logic [3:0]            alu_op,
  output logic [DATA_W-1:0]     alu_src0,
  output logic [DATA_W-1:0]     alu_src1,
  output logic [DATA_W-1:0]     alu_imm,
  output logic [2:0]            alu_flag_reg,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [2:0]            alu_flags
);

  import alu_pkg::*;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e              state_q,      state_d;
  logic                last_gnt_q,   last_gnt_d;
  logic                owner_q,      owner_d;
  logic [3:0]          alu_op_q,     alu_op_d;
  logic [DATA_W-1:0]   alu_src0_q,   alu_src0_d;
  logic [DATA_W-1:0]   alu_src1_q,   alu_src1_d;
  logic [DATA_W-1:0]   alu_imm_q,    alu_imm_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic [2:0]          rsp_flags_q,  rsp_flags_d;
  logic [2:0]          flag_q,       flag_d;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic       rsp_hs;     // owner accepts the pending response this cycle
  logic       arb_en;     // a new op may be accepted this cycle
  logic [1:0] gnt;
  logic       req_hs;     // a request handshakes this cycle
  logic       sel;        // index of the granted requester

  // Only the owner's rsp_ready matters; the other bit is ignored.
  assign rsp_hs = (state_q == ST_RESP) && rsp_ready[owner_q];

  // New work is accepted when idle, or when the current response retires in
  // the same cycle, which keeps back-to-back ops at one per two cycles.
  assign arb_en = (state_q == ST_IDLE) || rsp_hs;

  rr_arb2 u_arb (
    .req      (req_valid),
    .last_gnt (last_gnt_q),
    .en       (arb_en),
    .gnt      (gnt)
  );

  // The arbiter only grants valid requesters, so any grant is a handshake.
  assign req_hs = |gnt;
  assign sel    = gnt[1];

  // --------------------------------------------------------------------------
  // Next-state and datapath capture
  // --------------------------------------------------------------------------
  // Sequences IDLE -> ISSUE -> RESP, loads the ALU buses on a grant and
  // captures the ALU output at the end of the issue cycle.
  always_comb begin
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    owner_d      = owner_q;
    alu_op_d     = alu_op_q;
    alu_src0_d   = alu_src0_q;
    alu_src1_d   = alu_src1_q;
    alu_imm_d    = alu_imm_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    flag_d       = flag_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_hs) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // ALU inputs have been stable for the whole cycle; take its output.
        rsp_result_d = alu_result;
        rsp_flags_d  = alu_flags;
        if (FLAG_WR_MASK[owner_q]) begin
          flag_d = alu_flags;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_hs) begin
          state_d = req_hs ? ST_ISSUE : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A granted request is registered onto the ALU buses and becomes the
    // owner of the next response.
    if (req_hs) begin
      owner_d    = sel;
      last_gnt_d = sel;
      alu_op_d   = sel ? req_op[7:4]               : req_op[3:0];
      alu_src0_d = sel ? req_src0[2*DATA_W-1:DATA_W] : req_src0[DATA_W-1:0];
      alu_src1_d = sel ? req_src1[2*DATA_W-1:DATA_W] : req_src1[DATA_W-1:0];
      alu_imm_d  = sel ? req_imm[2*DATA_W-1:DATA_W]  : req_imm[DATA_W-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // Reset discards any in-flight op; last_gnt = 1 lets requester 0 win first
  // and the ALU buses come up as ADD 0+0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_gnt_q   <= 1'b1;
      owner_q      <= 1'b0;
      alu_op_q     <= OP_ADD;
      alu_src0_q   <= '0;
      alu_src1_q   <= '0;
      alu_imm_q    <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= 3'b000;
      flag_q       <= 3'b000;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      owner_q      <= owner_d;
      alu_op_q     <= alu_op_d;
      alu_src0_q   <= alu_src0_d;
      alu_src1_q   <= alu_src1_d;
      alu_imm_q    <= alu_imm_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      flag_q       <= flag_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req_ready    = gnt;
  assign rsp_valid    = (state_q == ST_RESP) ? onehot2(owner_q) : 2'b00;
  assign rsp_result   = rsp_result_q;
  assign rsp_flags    = rsp_flags_q;
  assign alu_op       = alu_op_q;
  assign alu_src0     = alu_src0_q;
  assign alu_src1     = alu_src1_q;
  assign alu_imm      = alu_imm_q;
  assign alu_flag_reg = flag_q;

endmodule : alu_share_ctrl
`default_nettype wire
